// File: rtl/kd_tree_ctrl.sv
// KD-tree job controller: loads node configuration into the tree, streams query
// patches through it and returns leaf indices in issue order via a small result FIFO.
module kd_tree_ctrl #(
   parameter int INTERNAL_WIDTH = 22,
   parameter int PATCH_WIDTH    = 55,
   parameter int ADDRESS_WIDTH  = 8,
   parameter int NUM_NODES      = 127,
   parameter int TREE_LATENCY   = 7,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [15:0]               num_queries,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [INTERNAL_WIDTH-1:0] cfg_data,
   input  logic                      patch_valid,
   output logic                      patch_ready,
   input  logic [PATCH_WIDTH-1:0]    patch_data,
   output logic                      tree_rst_n,
   output logic                      fsm_enable,
   output logic                      sender_enable,
   output logic [INTERNAL_WIDTH-1:0] sender_data,
   output logic [PATCH_WIDTH-1:0]    patch_in,
   input  logic [ADDRESS_WIDTH-1:0]  leaf_index,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [ADDRESS_WIDTH-1:0]  res_leaf,
   output logic [15:0]               res_qid,
   output logic                      busy,
   output logic                      done
);

   localparam int FAW    = $clog2(FIFO_DEPTH);
   localparam int PIPE_N = TREE_LATENCY + 1;
   localparam int RW     = 16 + ADDRESS_WIDTH;

   typedef enum logic [2:0] {IDLE, LOAD, QUERY, DRAIN, DONE} state_t;

   state_t                state;
   logic [15:0]           nq_lat;
   logic [15:0]           node_cnt;
   logic [15:0]           issued;
   logic                  load_first;
   logic [PIPE_N-1:0]     vld_p;
   logic [15:0]           qid_p [PIPE_N];
   logic [RW-1:0]         fifo_mem [FIFO_DEPTH];
   logic [FAW-1:0]        wr_ptr;
   logic [FAW-1:0]        rd_ptr;
   logic [FAW:0]          fifo_cnt;
   logic [15:0]           inflight;
   logic [15:0]           credit_used;
   logic                  patch_acc;
   logic                  push;
   logic                  pop;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < PIPE_N; i++) inflight = inflight + 16'(vld_p[i]);
   end

   // Credit covers both results still inside the tree and results parked in the FIFO.
   assign credit_used   = inflight + 16'(fifo_cnt);
   assign cfg_ready     = (state == LOAD) && !load_first;
   assign fsm_enable    = (state == LOAD);
   assign sender_enable = cfg_valid && cfg_ready;
   assign sender_data   = cfg_data;
   assign tree_rst_n    = !(rst || load_first);
   assign patch_ready   = (state == QUERY) && (issued < nq_lat) &&
                          (credit_used < 16'(FIFO_DEPTH));
   assign patch_acc     = patch_valid && patch_ready;
   assign push          = vld_p[PIPE_N-1];
   assign res_valid     = (fifo_cnt != '0);
   assign pop           = res_valid && res_ready;
   assign {res_qid, res_leaf} = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         nq_lat     <= '0;
         node_cnt   <= '0;
         issued     <= '0;
         load_first <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done       <= 1'b0;
         load_first <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state      <= LOAD;
               nq_lat     <= num_queries;
               node_cnt   <= '0;
               issued     <= '0;
               load_first <= 1'b1;
               busy       <= 1'b1;
            end
            LOAD: if (sender_enable) begin
               node_cnt <= node_cnt + 16'd1;
               if (node_cnt == 16'(NUM_NODES - 1)) begin
                  if (nq_lat != '0) begin
                     state <= QUERY;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            QUERY: if (patch_acc) begin
               issued <= issued + 16'd1;
               if (issued == nq_lat - 16'd1) state <= DRAIN;
            end
            DRAIN: if (inflight == '0 && fifo_cnt == '0) begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stage p0: patch registered onto the tree root; qid rides alongside to the FIFO.
   always_ff @(posedge clk) begin
      if (rst) patch_in <= '0;
      else if (patch_acc) patch_in <= patch_data;
   end

   always_ff @(posedge clk) begin
      if (rst) vld_p <= '0;
      else if (state == IDLE && start) vld_p <= '0;
      else vld_p <= {vld_p[PIPE_N-2:0], patch_acc};
   end

   always_ff @(posedge clk) begin
      qid_p[0] <= issued;
      for (int i = 1; i < PIPE_N; i++) qid_p[i] <= qid_p[i-1];
   end

   // Last stage: leaf_index is valid for the entry now at the pipeline tail.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {qid_p[PIPE_N-1], leaf_index};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FAW'(1);
         if (pop)  rd_ptr <= rd_ptr + FAW'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (FAW+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (FAW+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && fifo_cnt == (FAW+1)'(FIFO_DEPTH)));

endmodule

// File: doc/kd_tree_ctrl.md
KD_TREE_CTRL -- requirements
Module: kd_tree_ctrl

Interface
REQ-001 SHALL take parameters: INTERNAL_WIDTH, default 22, internal-node config word width; PATCH_WIDTH, default 55, query patch width; ADDRESS_WIDTH, default 8, leaf index width; NUM_NODES, default 127, internal nodes to load; TREE_LATENCY, default 7, cycles from patch_in driven to leaf_index valid; FIFO_DEPTH, default 8, result FIFO entries (power of 2, >= 2).
REQ-002 SHALL have ports (name  direction  width  meaning):
clk  in  1  single clock, all logic rising-edge
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to begin a load+query job
num_queries  in  16  patches in the job, sampled when start is accepted
cfg_valid / cfg_ready  in / out  1 / 1  config stream handshake
cfg_data  in  INTERNAL_WIDTH  node config word
patch_valid / patch_ready  in / out  1 / 1  query stream handshake
patch_data  in  PATCH_WIDTH  query patch
tree_rst_n  out  1  active-low clear to node tree
fsm_enable  out  1  tree write phase enable
sender_enable  out  1  tree write strobe
sender_data  out  INTERNAL_WIDTH  tree write data
patch_in  out  PATCH_WIDTH  patch driven into tree root
leaf_index  in  ADDRESS_WIDTH  tree result
res_valid / res_ready  out / in  1 / 1  result stream handshake
res_leaf  out  ADDRESS_WIDTH  leaf index of result
res_qid  out  16  query ordinal (0-based) of result
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at job completion

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, QUERY, DRAIN, DONE.
REQ-004 IDLE: cfg_ready=0, patch_ready=0; start=1 -> LOAD, latch num_queries, clear node counter, query counters, issue pipeline; start outside IDLE SHALL be ignored.
REQ-005 tree_rst_n SHALL be 0 while rst=1 and for exactly the first cycle in LOAD, 1 otherwise.
REQ-006 LOAD: fsm_enable=1; cfg_ready=1 except in the tree_rst_n=0 cycle; sender_enable=cfg_valid&&cfg_ready (combinational); sender_data=cfg_data (combinational).
REQ-007 Node counter SHALL increment per accepted cfg beat; on the NUM_NODES-th beat -> QUERY if latched num_queries>0, else -> DONE.
REQ-008 Outside LOAD: fsm_enable=0, sender_enable=0, cfg_ready=0.
REQ-009 QUERY: patch_ready=1 iff issued<num_queries and (inflight+fifo_count)<FIFO_DEPTH; inflight = valid bits in issue pipeline.
REQ-010 Accepted patch at cycle T SHALL be registered onto patch_in from T+1, holding until next accept; issue pipeline (TREE_LATENCY+1 stages, valid+qid) SHALL deliver leaf_index sampled at T+1+TREE_LATENCY into the FIFO with its qid.
REQ-011 On accepting the last patch (issued reaches num_queries) -> DRAIN.
REQ-012 DRAIN: patch_ready=0; inflight=0 and FIFO empty -> DONE.
REQ-013 DONE: done=1 for one cycle, then IDLE unconditionally.
REQ-014 Result FIFO: first-word-fall-through; res_valid=!empty; pop on res_valid&&res_ready; simultaneous push and pop SHALL both occur with count unchanged; credit rule (REQ-009) guarantees no overflow, push when full is a design error flagged by assertion.
REQ-015 res_qid SHALL increase by 1 per result in issue order, starting at 0 per job; results never reordered.
REQ-016 Counters 16-bit; num_queries=65535 SHALL complete without wrap error.
REQ-017 Back-to-back accepts allowed every cycle while credit available; sustained throughput 1 patch/cycle with res_ready=1.

Reset
REQ-018 rst=1 SHALL force IDLE, all counters 0, pipeline valids 0, FIFO empty, busy=0, done=0, res_valid=0, cfg_ready=0, patch_ready=0, fsm_enable=0, sender_enable=0, patch_in=0, tree_rst_n=0, regardless of state (mid-LOAD or mid-QUERY included).

Verification
REQ-019 start, num_queries=3, 127 cfg beats back-to-back -> sender_enable pulses exactly 127 times with matching data, tree_rst_n low 1 cycle at LOAD entry, state QUERY at cycle after beat 127.
REQ-020 3 patches accepted T,T+1,T+2, res_ready=1, tree model returning 5,9,200 -> res_valid at T+9..T+11 (FIFO write at T+8, FWFT), qid 0,1,2, leaves 5,9,200; done one cycle after FIFO empties.
REQ-021 res_ready=0, num_queries=20 -> patch_ready drops after exactly 8 accepts; raising res_ready resumes; all 20 results in order, no overflow assertion.
REQ-022 num_queries=0 -> after 127 cfg beats, done pulses with no patch_ready ever high and no res_valid.
REQ-023 rst=1 mid-QUERY with 4 in flight -> next cycle IDLE, res_valid=0, busy=0; new start runs a clean job with qid from 0.
REQ-024 start pulsed during QUERY -> ignored, job completes with original num_queries.
